// File: rtl/rptr_empty.sv
// ============================================================================
// Module   : rptr_empty
// Purpose  : Read-side pointer, empty/almost-empty and level logic of an
//            asynchronous FIFO, with write-pointer synchronizer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rptr_empty #(
    parameter int add_size  = 4,
    parameter int ae_thresh = 1
) (
    input  logic                rd_clk,
    input  logic                rd_rst,
    input  logic                rd_inc,
    input  logic [add_size:0]   wr_ptr,
    output logic [add_size-1:0] rd_addr,
    output logic [add_size:0]   rd_ptr,
    output logic                empty,
    output logic                almost_empty,
    output logic [add_size:0]   rd_level,
    output logic                underflow
);

    localparam logic [add_size+1:0] C_AE_THRESH = (add_size+2)'(ae_thresh);

    logic [add_size:0] sync1_q;
    logic [add_size:0] wq2_ptr_q;
    logic [add_size:0] rbin_q,  rbin_d;
    logic [add_size:0] rd_ptr_q, rd_ptr_d;
    logic [add_size:0] level_q, level_d;
    logic              empty_q, empty_d;
    logic              ae_q,    ae_d;
    logic              uflow_q, uflow_d;
    logic [add_size:0] wq2_bin;
    logic              rd_en;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    for (genvar i = 0; i <= add_size; i++) begin : g_g2b
        assign wq2_bin[i] = ^(wq2_ptr_q >> i);
    end

    always_comb begin
        rd_en    = rd_inc & ~empty_q;
        rbin_d   = rbin_q + (add_size+1)'(rd_en);
        rd_ptr_d = (rbin_d >> 1) ^ rbin_d;
        level_d  = wq2_bin - rbin_d;
        empty_d  = (rd_ptr_d == wq2_ptr_q);
        // Empty implies level 0, so this also covers ae_thresh = 0.
        ae_d     = empty_d | ({1'b0, level_d} <= C_AE_THRESH);
        uflow_d  = uflow_q | (rd_inc & empty_q);
    end

    // Plain two-flop synchronizer; nothing may sit between the stages.
    always_ff @(posedge rd_clk or negedge rd_rst) begin
        if (!rd_rst) begin
            sync1_q   <= '0;
            wq2_ptr_q <= '0;
        end else begin
            sync1_q   <= wr_ptr;
            wq2_ptr_q <= sync1_q;
        end
    end

    always_ff @(posedge rd_clk or negedge rd_rst) begin
        if (!rd_rst) begin
            rbin_q   <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            ae_q     <= 1'b1;
            uflow_q  <= 1'b0;
        end else begin
            rbin_q   <= rbin_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            empty_q  <= empty_d;
            ae_q     <= ae_d;
            uflow_q  <= uflow_d;
        end
    end

    assign rd_addr      = rbin_q[add_size-1:0];
    assign rd_ptr       = rd_ptr_q;
    assign empty        = empty_q;
    assign almost_empty = ae_q;
    assign rd_level     = level_q;
    assign underflow    = uflow_q;

endmodule

`default_nettype wire

// File: tb/tb_rptr_empty.sv
// ============================================================================
// Module   : tb_rptr_empty
// Purpose  : Directed self-checking bench for rptr_empty (add_size=4, ae=1).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rptr_empty;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rd_inc;
    logic [4:0] wr_ptr;
    logic [3:0] rd_addr;
    logic [4:0] rd_ptr;
    logic       empty;
    logic       almost_empty;
    logic [4:0] rd_level;
    logic       underflow;

    int n_tests = 0;
    int n_fail  = 0;

    rptr_empty #(.add_size(4), .ae_thresh(1)) dut (
        .rd_clk       (clk),
        .rd_rst       (rst_n),
        .rd_inc       (rd_inc),
        .wr_ptr       (wr_ptr),
        .rd_addr      (rd_addr),
        .rd_ptr       (rd_ptr),
        .empty        (empty),
        .almost_empty (almost_empty),
        .rd_level     (rd_level),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        n_tests++;
        if ({rd_ptr, rd_addr, empty, almost_empty, rd_level, underflow} !==
            {5'b00000, 4'd0, 1'b1, 1'b1, 5'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL %s: ptr=%b addr=%0d e=%b ae=%b lvl=%0d uf=%b, required ptr=00000 addr=0 e=1 ae=1 lvl=0 uf=0",
                     tag, rd_ptr, rd_addr, empty, almost_empty, rd_level, underflow);
        end
    endtask

    task automatic do_reset;
        rd_inc = 1'b0;
        wr_ptr = 5'b00000;
        rst_n  = 1'b0;
        tick(2);
        rst_n  = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        check_reset_vals("reset_state");
        tick(3);
        check_reset_vals("idle_after_reset");
    endtask

    task automatic test_latency_and_reads;
        wr_ptr = 5'b00010;
        tick(2);
        n_tests++;
        if (empty !== 1'b1) begin
            n_fail++;
            $display("FAIL latency_edge2: empty=%b, required 1", empty);
        end
        tick(1);
        n_tests++;
        if ({empty, rd_level, almost_empty} !== {1'b0, 5'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL latency_edge3: e=%b lvl=%0d ae=%b, required e=0 lvl=3 ae=0",
                     empty, rd_level, almost_empty);
        end
        rd_inc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (rd_addr !== 4'(i)) begin
                n_fail++;
                $display("FAIL read_addr_%0d: addr=%0d, required %0d", i, rd_addr, i);
            end
            tick(1);
            if (i == 0) begin
                n_tests++;
                if (almost_empty !== 1'b0 || rd_level !== 5'd2) begin
                    n_fail++;
                    $display("FAIL after_read1: ae=%b lvl=%0d, required ae=0 lvl=2", almost_empty, rd_level);
                end
            end
            if (i == 1) begin
                n_tests++;
                if (almost_empty !== 1'b1 || empty !== 1'b0) begin
                    n_fail++;
                    $display("FAIL after_read2: ae=%b e=%b, required ae=1 e=0", almost_empty, empty);
                end
            end
        end
        rd_inc = 1'b0;
        n_tests++;
        if ({empty, rd_ptr, rd_level, rd_addr} !== {1'b1, 5'b00010, 5'd0, 4'd3}) begin
            n_fail++;
            $display("FAIL after_read3: e=%b ptr=%b lvl=%0d addr=%0d, required e=1 ptr=00010 lvl=0 addr=3",
                     empty, rd_ptr, rd_level, rd_addr);
        end
    endtask

    task automatic test_underflow;
        n_tests++;
        if (underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL underflow_pre: uf=%b, required 0", underflow);
        end
        rd_inc = 1'b1;
        tick(1);
        n_tests++;
        if ({underflow, rd_addr, rd_ptr} !== {1'b1, 4'd3, 5'b00010}) begin
            n_fail++;
            $display("FAIL underflow_set: uf=%b addr=%0d ptr=%b, required uf=1 addr=3 ptr=00010",
                     underflow, rd_addr, rd_ptr);
        end
        rd_inc = 1'b0;
        tick(2);
        n_tests++;
        if (underflow !== 1'b1) begin
            n_fail++;
            $display("FAIL underflow_sticky: uf=%b, required 1", underflow);
        end
    endtask

    task automatic test_full_wrap;
        logic [4:0] prev;
        do_reset();
        wr_ptr = 5'b11000;
        tick(3);
        n_tests++;
        if ({rd_level, empty, almost_empty} !== {5'd16, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL full_level: lvl=%0d e=%b ae=%b, required lvl=16 e=0 ae=0",
                     rd_level, empty, almost_empty);
        end
        rd_inc = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_tests++;
            if (rd_addr !== 4'(i)) begin
                n_fail++;
                $display("FAIL wrap_addr_%0d: addr=%0d, required %0d", i, rd_addr, i);
            end
            prev = rd_ptr;
            tick(1);
            n_tests++;
            if ($countones(prev ^ rd_ptr) != 1) begin
                n_fail++;
                $display("FAIL gray_step_%0d: %b -> %b, required one bit change", i, prev, rd_ptr);
            end
        end
        rd_inc = 1'b0;
        n_tests++;
        if ({rd_addr, rd_ptr, empty, rd_level} !== {4'd0, 5'b11000, 1'b1, 5'd0}) begin
            n_fail++;
            $display("FAIL wrap_end: addr=%0d ptr=%b e=%b lvl=%0d, required addr=0 ptr=11000 e=1 lvl=0",
                     rd_addr, rd_ptr, empty, rd_level);
        end
    endtask

    task automatic test_reset_mid_op;
        do_reset();
        wr_ptr = 5'b00111;
        tick(3);
        n_tests++;
        if (rd_level !== 5'd5) begin
            n_fail++;
            $display("FAIL mid_level: lvl=%0d, required 5", rd_level);
        end
        rd_inc = 1'b1;
        tick(1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_reset");
        tick(3);
        check_reset_vals("reset_held");
        rd_inc = 1'b0;
        rst_n  = 1'b1;
        tick(3);
        n_tests++;
        if ({empty, rd_level, rd_addr} !== {1'b0, 5'd5, 4'd0}) begin
            n_fail++;
            $display("FAIL post_reset_resume: e=%b lvl=%0d addr=%0d, required e=0 lvl=5 addr=0",
                     empty, rd_level, rd_addr);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        rd_inc = 1'b0;
        wr_ptr = 5'b00000;
        test_reset();
        test_latency_and_reads();
        test_underflow();
        test_full_wrap();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
